// File: rtl/inst_pool_q.sv
// Instruction pool between decode stage 2 and scheduler 1: a DEPTH-entry circular
// queue whose oldest PNUMS entries are presented to the scheduler as parallel slots.
module inst_pool_q #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PNUMS = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned AW = $clog2(PNUMS + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                FLUSH,
    input  logic                STALL,
    input  logic                MMU_WAIT,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [31:0]         PC,
    input  logic [16:0]         OPCODE,
    input  logic [4:0]          RD,
    input  logic [4:0]          RS1,
    input  logic [4:0]          RS2,
    input  logic [31:0]         RINST,
    output logic [PNUMS-1:0]    POOL_VALID,
    output logic [32*PNUMS-1:0] POOL_PC,
    output logic [17*PNUMS-1:0] POOL_OPCODE,
    output logic [5*PNUMS-1:0]  POOL_RD,
    output logic [5*PNUMS-1:0]  POOL_RS1,
    output logic [5*PNUMS-1:0]  POOL_RS2,
    output logic [32*PNUMS-1:0] POOL_RINST,
    input  logic [AW-1:0]       POOL_ACCEPT,
    output logic [CW-1:0]       COUNT
);

    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [31:0] NOP_RINST   = 32'h0000_0013;
    localparam logic [16:0] NOP_OPCODE  = 17'h1C000;

    typedef struct packed {
        logic [31:0] pc;
        logic [16:0] opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rinst;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic            hold;
    logic            enq;
    logic [CW-1:0]   acc_w;
    logic [CW-1:0]   deq;
    entry_t          in_e;

    // Ready depends on the registered count only: a full pool stays closed even while draining.
    assign IN_READY = (count_q < CW'(DEPTH));
    assign COUNT    = count_q;

    // Next-state: pointer/count update with flush priority over hold.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        in_e    = '{pc: PC, opcode: OPCODE, rd: RD, rs1: RS1, rs2: RS2, rinst: RINST};
        hold    = STALL | MMU_WAIT;
        enq     = IN_VALID & IN_READY & ~hold;
        acc_w   = CW'(POOL_ACCEPT);
        // Over-accept is clamped to the occupancy so the count can never underflow.
        deq     = hold ? '0 : ((acc_w > count_q) ? count_q : acc_w);
        if (FLUSH) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(deq);
            tail_d  = tail_q + PW'(enq);
            count_d = count_q + CW'(enq) - deq;
            if (enq) begin
                mem_d[tail_q] = in_e;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry contents are never cleared; only the occupancy decides what is visible.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            mem_q <= mem_d;
        end
    end

    // Slot view: oldest entries first, invalid slots forced to a NOP pattern.
    always_comb begin
        logic [PW-1:0] idx;
        entry_t        e;
        POOL_VALID  = '0;
        POOL_PC     = '0;
        POOL_OPCODE = '0;
        POOL_RD     = '0;
        POOL_RS1    = '0;
        POOL_RS2    = '0;
        POOL_RINST  = '0;
        idx         = '0;
        e           = '0;
        for (int i = 0; i < int'(PNUMS); i++) begin
            idx = head_q + PW'(i);
            e   = mem_q[idx];
            if (CW'(i) < count_q) begin
                POOL_VALID[i]            = 1'b1;
                POOL_PC[32*i +: 32]      = e.pc;
                POOL_OPCODE[17*i +: 17]  = e.opcode;
                POOL_RD[5*i +: 5]        = e.rd;
                POOL_RS1[5*i +: 5]       = e.rs1;
                POOL_RS2[5*i +: 5]       = e.rs2;
                POOL_RINST[32*i +: 32]   = e.rinst;
            end else begin
                POOL_OPCODE[17*i +: 17]  = NOP_OPCODE;
                POOL_RINST[32*i +: 32]   = NOP_RINST;
            end
        end
    end

endmodule

// File: tb/tb_inst_pool_q.sv
// Directed self-checking bench for inst_pool_q (DEPTH=8, PNUMS=2).
module tb_inst_pool_q;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PNUMS = 2;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(PNUMS + 1);

    logic                CLK = 1'b0;
    logic                RST;
    logic                FLUSH;
    logic                STALL;
    logic                MMU_WAIT;
    logic                IN_VALID;
    logic                IN_READY;
    logic [31:0]         PC;
    logic [16:0]         OPCODE;
    logic [4:0]          RD;
    logic [4:0]          RS1;
    logic [4:0]          RS2;
    logic [31:0]         RINST;
    logic [PNUMS-1:0]    POOL_VALID;
    logic [32*PNUMS-1:0] POOL_PC;
    logic [17*PNUMS-1:0] POOL_OPCODE;
    logic [5*PNUMS-1:0]  POOL_RD;
    logic [5*PNUMS-1:0]  POOL_RS1;
    logic [5*PNUMS-1:0]  POOL_RS2;
    logic [32*PNUMS-1:0] POOL_RINST;
    logic [AW-1:0]       POOL_ACCEPT;
    logic [CW-1:0]       COUNT;

    int total = 0;
    int bad   = 0;

    inst_pool_q #(.DEPTH(DEPTH), .PNUMS(PNUMS)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL), .MMU_WAIT(MMU_WAIT),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .PC(PC), .OPCODE(OPCODE),
        .RD(RD), .RS1(RS1), .RS2(RS2), .RINST(RINST),
        .POOL_VALID(POOL_VALID), .POOL_PC(POOL_PC), .POOL_OPCODE(POOL_OPCODE),
        .POOL_RD(POOL_RD), .POOL_RS1(POOL_RS1), .POOL_RS2(POOL_RS2),
        .POOL_RINST(POOL_RINST), .POOL_ACCEPT(POOL_ACCEPT), .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs are settled 1ns after the edge.
    task automatic step(input logic iv, input logic [31:0] pc, input int acc,
                        input logic stall, input logic flush, input logic rst);
        IN_VALID    = iv;
        PC          = pc;
        OPCODE      = pc[16:0] ^ 17'h00155;
        RD          = pc[6:2];
        RS1         = pc[7:3];
        RS2         = pc[8:4];
        RINST       = ~pc;
        POOL_ACCEPT = AW'(acc);
        STALL       = stall;
        FLUSH       = flush;
        RST         = rst;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] spc(input int i);
        return POOL_PC[32*i +: 32];
    endfunction

    initial begin
        MMU_WAIT = 1'b0;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        RST = 1'b0;
        #1;
        // Reset state
        chk("rst_count", 64'(COUNT), 0);
        chk("rst_valid", 64'(POOL_VALID), 0);
        chk("rst_ready", 64'(IN_READY), 1);
        chk("rst_pc0", 64'(spc(0)), 0);
        chk("rst_opc0", 64'(POOL_OPCODE[16:0]), 64'h1C000);
        chk("rst_rinst1", 64'(POOL_RINST[63:32]), 64'h13);

        // Three enqueues, nothing accepted
        step(1, 32'h100, 0, 0, 0, 0);
        chk("lat1_count", 64'(COUNT), 1);
        chk("lat1_pc0", 64'(spc(0)), 64'h100);
        chk("lat1_valid", 64'(POOL_VALID), 64'b01);
        step(1, 32'h104, 0, 0, 0, 0);
        step(1, 32'h108, 0, 0, 0, 0);
        chk("t1_count", 64'(COUNT), 3);
        chk("t1_valid", 64'(POOL_VALID), 64'b11);
        chk("t1_pc0", 64'(spc(0)), 64'h100);
        chk("t1_pc1", 64'(spc(1)), 64'h104);
        chk("t1_opc0", 64'(POOL_OPCODE[16:0]), 64'h00055);
        chk("t1_rs2_1", 64'(POOL_RS2[9:5]), 64'h10);
        chk("t1_rinst1", 64'(POOL_RINST[63:32]), 64'hFFFF_FEFB);

        // Fill to DEPTH, then accept 2 while decode still offers
        for (int k = 0; k < 5; k++) step(1, 32'h10C + 32'(4*k), 0, 0, 0, 0);
        chk("t2_full_count", 64'(COUNT), 8);
        chk("t2_full_ready", 64'(IN_READY), 0);
        step(1, 32'h200, 2, 0, 0, 0);
        chk("t2_count", 64'(COUNT), 6);
        chk("t2_ready", 64'(IN_READY), 1);
        chk("t2_pc0", 64'(spc(0)), 64'h108);

        // Steady enq + accept 1 across the pointer wrap
        for (int k = 0; k < 20; k++) begin
            chk("t3_pre_pc0", 64'(spc(0)), 64'(32'h108 + 32'(4*k)));
            step(1, 32'h120 + 32'(4*k), 1, 0, 0, 0);
            chk("t3_count", 64'(COUNT), 6);
            chk("t3_pc1", 64'(spc(1)), 64'(32'h110 + 32'(4*k)));
        end
        chk("t3_end_pc0", 64'(spc(0)), 64'h158);

        // Stall freezes everything, release resumes exactly
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h300, 2, 1, 0, 0);
            chk("t4_count", 64'(COUNT), 6);
            chk("t4_pc0", 64'(spc(0)), 64'h158);
            chk("t4_pc1", 64'(spc(1)), 64'h15C);
        end
        MMU_WAIT = 1'b1;
        step(1, 32'h310, 2, 0, 0, 0);
        MMU_WAIT = 1'b0;
        chk("t4_mmu_count", 64'(COUNT), 6);
        step(0, 0, 2, 0, 0, 0);
        chk("t4_rel_count", 64'(COUNT), 4);
        chk("t4_rel_pc0", 64'(spc(0)), 64'h160);
        chk("t4_rel_pc1", 64'(spc(1)), 64'h164);

        // Flush at COUNT=5 with a concurrent offer and accept
        step(1, 32'h170, 0, 0, 0, 0);
        chk("t5_pre_count", 64'(COUNT), 5);
        step(1, 32'h400, 1, 0, 1, 0);
        chk("t5_count", 64'(COUNT), 0);
        chk("t5_valid", 64'(POOL_VALID), 0);
        chk("t5_rinst0", 64'(POOL_RINST[31:0]), 64'h13);
        chk("t5_pc0", 64'(spc(0)), 0);
        step(1, 32'h500, 0, 0, 0, 0);
        chk("t5_after_count", 64'(COUNT), 1);
        chk("t5_after_pc0", 64'(spc(0)), 64'h500);
        chk("t5_after_valid", 64'(POOL_VALID), 64'b01);
        chk("t5_after_rinst1", 64'(POOL_RINST[63:32]), 64'h13);

        // Over-accept is clamped; head advances by exactly one
        step(0, 0, 2, 0, 0, 0);
        chk("t6_count", 64'(COUNT), 0);
        chk("t6_valid", 64'(POOL_VALID), 0);
        chk("t6_ready", 64'(IN_READY), 1);
        step(1, 32'h600, 1, 0, 0, 0);
        chk("t6_enq_count", 64'(COUNT), 1);
        chk("t6_enq_pc0", 64'(spc(0)), 64'h600);
        step(1, 32'h604, 1, 0, 0, 0);
        chk("t6_swap_count", 64'(COUNT), 1);
        chk("t6_swap_pc0", 64'(spc(0)), 64'h604);

        // Reset mid-operation drops the in-flight enqueue
        step(1, 32'h700, 1, 0, 0, 1);
        chk("rst2_count", 64'(COUNT), 0);
        chk("rst2_valid", 64'(POOL_VALID), 0);
        step(1, 32'h704, 0, 0, 0, 0);
        chk("rst2_after_pc0", 64'(spc(0)), 64'h704);
        chk("rst2_after_count", 64'(COUNT), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
